// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types for the FIFO drain UART.
// Frame FSM states, parity modes and data width.
package fifo_uart_pkg;

  localparam int DATA_W   = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clk cycles inside one UART bit.
// bit_done marks the last cycle of each bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign bit_done = (cnt_q == 16'(CLKS_PER_BIT - 1));

  // Next count: restart on clear or at the end of a bit
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the sample FIFO read port
// and sends each as an 8N1/8O/8E UART frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_do,
  output logic        fifo_re,
  output logic        tx,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          idx_q, idx_d;
  logic                stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                re_q, re_d;
  logic                busy_q, busy_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                bit_done;
  logic                tmr_clear;
  logic                par_bit;

  // Parity always comes from the captured byte
  assign par_bit = (PARITY == PAR_EVEN) ? ^data_q : ~^data_q;

  // Timer restarts whenever the FSM changes state
  assign tmr_clear = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .bit_done (bit_done)
  );

  // Frame FSM next state plus registered-output next values
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        data_d  = fifo_do;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    re_d   = (state_d == ST_FETCH);
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[idx_d];
      ST_PARITY: tx_d = par_bit;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, shift data and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx       = tx_q;
  assign fifo_re  = re_q;
  assign busy     = busy_q;
  assign byte_cnt = cnt_q;

endmodule
